// File: rtl/aes_block_loader.sv
// Packs 32-bit host words into 128-bit AES key and message blocks.
// Compile option AES_LOADER_BSWAP_EN byte-reverses each input word.
module aes_block_loader #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_is_key,
    output logic              blk_valid,
    input  logic              blk_ready,
    output logic [127:0]      blk_msg,
    output logic [127:0]      blk_key,
    output logic              key_loaded,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, ACC_KEY, ACC_MSG, PRESENT} state_t;

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [95:0]  shd_q, shd_d;
    logic [127:0] msg_q, msg_d;
    logic [127:0] key_q, key_d;
    logic         kl_q, kl_d;
    logic         err_q, err_d;
    logic [31:0]  word;
    logic         xfer;

`ifdef AES_LOADER_BSWAP_EN
    assign word = {in_data[7:0], in_data[15:8], in_data[23:16], in_data[31:24]};
`else
    assign word = in_data;
`endif

    assign in_ready   = ~rst & (state_q != PRESENT);
    assign xfer       = in_valid & in_ready;
    assign blk_valid  = (state_q == PRESENT);
    assign blk_msg    = msg_q;
    assign blk_key    = key_q;
    assign key_loaded = kl_q;
    assign err        = err_q;

    // One shadow holds the first three words of whichever group is open
    function automatic logic [95:0] put(input logic [95:0] s,
                                        input logic [1:0]  i,
                                        input logic [31:0] w);
        logic [95:0] r;
        r = s;
        case (i)
            2'd0:    r[95:64] = w;
            2'd1:    r[63:32] = w;
            default: r[31:0]  = w;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shd_d   = shd_q;
        msg_d   = msg_q;
        key_d   = key_q;
        kl_d    = kl_q;
        err_d   = 1'b0;
        if (xfer && in_is_key) begin
            if (state_q == ACC_KEY) begin
                if (cnt_q == 2'd3) begin
                    key_d   = {shd_q, word};
                    kl_d    = 1'b1;
                    cnt_d   = 2'd0;
                    state_d = IDLE;
                end else begin
                    shd_d = put(shd_q, cnt_q, word);
                    cnt_d = cnt_q + 2'd1;
                end
            end else begin
                err_d   = (state_q == ACC_MSG);
                shd_d   = put(shd_q, 2'd0, word);
                cnt_d   = 2'd1;
                state_d = ACC_KEY;
            end
        end else if (xfer) begin
            if (state_q == ACC_MSG) begin
                if (cnt_q == 2'd3) begin
                    msg_d   = {shd_q, word};
                    cnt_d   = 2'd0;
                    state_d = PRESENT;
                end else begin
                    shd_d = put(shd_q, cnt_q, word);
                    cnt_d = cnt_q + 2'd1;
                end
            end else if (kl_q) begin
                err_d   = (state_q == ACC_KEY);
                shd_d   = put(shd_q, 2'd0, word);
                cnt_d   = 2'd1;
                state_d = ACC_MSG;
            end else begin
                // No key yet: drop the word and any partial key group
                err_d   = 1'b1;
                cnt_d   = 2'd0;
                state_d = IDLE;
            end
        end else if (state_q == PRESENT && blk_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            shd_q   <= '0;
            msg_q   <= '0;
            key_q   <= '0;
            kl_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shd_q   <= shd_d;
            msg_q   <= msg_d;
            key_q   <= key_d;
            kl_q    <= kl_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Self-checking bench for aes_block_loader with a reference AES-128 model.
// Words are pre-swapped when AES_LOADER_BSWAP_EN is defined.
module tb_aes_block_loader;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] M1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] M2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_is_key = 1'b0;
    logic [31:0]  in_data = 32'h0;
    logic         blk_ready = 1'b1;
    logic         in_ready, blk_valid, key_loaded, err;
    logic [127:0] blk_msg, blk_key;

    aes_block_loader #(.WORD_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_is_key(in_is_key),
        .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_msg(blk_msg), .blk_key(blk_key),
        .key_loaded(key_loaded), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [127:0] k;
        logic [127:0] m;
        logic [127:0] c;
    } blk_t;
    blk_t sbq[$];

    typedef struct {
        logic         k;
        logic [31:0]  d;
        logic         e;
        logic [127:0] ek;
        logic         b;
        logic [127:0] bm;
        logic [127:0] bc;
    } vec_t;
    vec_t tv[20];

    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b};
        return t[15-n -: 8];
    endfunction

    function automatic logic [127:0] aes(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   st [16];
        logic [7:0]   tp [16];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] ct;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]}
                    ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++)
            st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) st[i] = sbox[st[i]];
            for (int i = 0; i < 16; i++) tp[i] = st[(i%4) + 4*(((i/4) + (i%4)) % 4)];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    st[4*c]   = xt(tp[4*c]) ^ xt(tp[4*c+1]) ^ tp[4*c+1] ^ tp[4*c+2] ^ tp[4*c+3];
                    st[4*c+1] = tp[4*c] ^ xt(tp[4*c+1]) ^ xt(tp[4*c+2]) ^ tp[4*c+2] ^ tp[4*c+3];
                    st[4*c+2] = tp[4*c] ^ tp[4*c+1] ^ xt(tp[4*c+2]) ^ xt(tp[4*c+3]) ^ tp[4*c+3];
                    st[4*c+3] = xt(tp[4*c]) ^ tp[4*c] ^ tp[4*c+1] ^ tp[4*c+2] ^ xt(tp[4*c+3]);
                end else begin
                    for (int j = 0; j < 4; j++) st[4*c+j] = tp[4*c+j];
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = st[i];
        return ct;
    endfunction

    function automatic logic [31:0] host(input logic [31:0] w);
`ifdef AES_LOADER_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic vec_t row(input logic k, input logic [31:0] d,
                                 input logic e, input logic [127:0] ek);
        vec_t v;
        v.k = k; v.d = d; v.e = e; v.ek = ek;
        v.b = 1'b0; v.bm = '0; v.bc = '0;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    // Scoreboard: pop an expected block on every rising blk_valid
    logic bv_prev = 1'b0;
    always @(negedge clk) begin
        blk_t e;
        if (blk_valid === 1'b1 && bv_prev !== 1'b1) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL blk_unexp: got block %h want none", blk_msg);
            end else begin
                e = sbq.pop_front();
                chk("blk_key", blk_key, e.k);
                chk("blk_msg", blk_msg, e.m);
                chk("cipher", aes(blk_key, blk_msg), e.c);
            end
        end
        bv_prev = blk_valid;
    end

    task automatic send(input logic k, input logic [31:0] d);
        int n;
        n = 0;
        in_valid  = 1'b1;
        in_is_key = k;
        in_data   = host(d);
        while (in_ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got in_ready %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic apply(input int i);
        if (tv[i].b) sbq.push_back('{tv[i].ek, tv[i].bm, tv[i].bc});
        send(tv[i].k, tv[i].d);
        chk($sformatf("err[%0d]", i), {127'h0, err}, {127'h0, tv[i].e});
        chk($sformatf("key[%0d]", i), blk_key, tv[i].ek);
        if (i == 4) chk("key_loaded", {127'h0, key_loaded}, 128'h1);
        @(posedge clk);
        #1;
        chk($sformatf("err_clr[%0d]", i), {127'h0, err}, 128'h0);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_ready"}, {127'h0, in_ready}, 128'h1);
        chk({nm, "_valid"}, {127'h0, blk_valid}, 128'h0);
        chk({nm, "_kl"}, {127'h0, key_loaded}, 128'h0);
        chk({nm, "_err"}, {127'h0, err}, 128'h0);
        chk({nm, "_msg"}, blk_msg, 128'h0);
        chk({nm, "_key"}, blk_key, 128'h0);
    endtask

    initial begin
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h0;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox[x] = b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
        end

        tv[0]  = row(1'b0, 32'h3243f6a8, 1'b1, '0);
        tv[1]  = row(1'b1, 32'h2b7e1516, 1'b0, '0);
        tv[2]  = row(1'b1, 32'h28aed2a6, 1'b0, '0);
        tv[3]  = row(1'b1, 32'habf71588, 1'b0, '0);
        tv[4]  = row(1'b1, 32'h09cf4f3c, 1'b0, K1);
        tv[5]  = row(1'b0, 32'h3243f6a8, 1'b0, K1);
        tv[6]  = row(1'b0, 32'h885a308d, 1'b0, K1);
        tv[7]  = row(1'b0, 32'h313198a2, 1'b0, K1);
        tv[8]  = row(1'b0, 32'he0370734, 1'b0, K1);
        tv[9]  = row(1'b0, 32'h00112233, 1'b0, K1);
        tv[10] = row(1'b0, 32'h44556677, 1'b0, K1);
        tv[11] = row(1'b1, 32'h00010203, 1'b1, K1);
        tv[12] = row(1'b1, 32'h04050607, 1'b0, K1);
        tv[13] = row(1'b1, 32'h08090a0b, 1'b0, K1);
        tv[14] = row(1'b1, 32'h0c0d0e0f, 1'b0, K2);
        tv[15] = row(1'b1, 32'hdeadbeef, 1'b0, K2);
        tv[16] = row(1'b0, 32'h00112233, 1'b1, K2);
        tv[17] = row(1'b0, 32'h44556677, 1'b0, K2);
        tv[18] = row(1'b0, 32'h8899aabb, 1'b0, K2);
        tv[19] = row(1'b0, 32'hccddeeff, 1'b0, K2);
        tv[8].b  = 1'b1; tv[8].bm  = M1; tv[8].bc  = C1;
        tv[19].b = 1'b1; tv[19].bm = M2; tv[19].bc = C2;

        chk("aes_ref", aes(K1, M1), C1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {127'h0, in_ready}, 128'h0);
        rst = 1'b0;
        #1;
        chk_reset("por");

        for (int i = 0; i < 20; i++) apply(i);

        // Block held in PRESENT while the core stalls
        blk_ready = 1'b0;
        sbq.push_back('{K2, M1, aes(K2, M1)});
        for (int j = 0; j < 4; j++) send(1'b0, M1[127-32*j -: 32]);
        for (int c = 0; c < 10; c++) begin
            chk("hold_valid", {127'h0, blk_valid}, 128'h1);
            chk("hold_ready", {127'h0, in_ready}, 128'h0);
            chk("hold_msg", blk_msg, M1);
            chk("hold_key", blk_key, K2);
            @(posedge clk);
            #1;
        end
        blk_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_valid", {127'h0, blk_valid}, 128'h0);
        chk("rel_ready", {127'h0, in_ready}, 128'h1);

        // Reset in the middle of a message group
        for (int j = 0; j < 3; j++) send(1'b0, M2[127-32*j -: 32]);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", {127'h0, in_ready}, 128'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk_reset("mid");
        for (int i = 1; i < 9; i++) apply(i);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", sbq.size(), 128'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
